// File: rtl/tan_clenshaw_seq_pkg.sv
// Shared constants for the tan(x*pi/4) Clenshaw evaluator: default sizes,
// odd Chebyshev coefficients (scale 256), recurrence fraction bits and FSM states.
package tan_pkg;

    localparam int W_DEF      = 9;
    localparam int L_DEF      = 5;
    localparam int IW_DEF     = W_DEF + 3;

    // Fraction bits: /128 inside the recurrence, /256 for the final combine.
    localparam int FRAC_STEP  = 7;
    localparam int FRAC_FINAL = 8;

    // Series coefficients c0..c5, scale 256.
    localparam int TAN_COEF [0:L_DEF] = '{0, 240, 0, 15, 0, 1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2
    } tan_state_e;

    // Coefficient lookup by term index; unused indices give zero.
    function automatic logic signed [IW_DEF-1:0] tan_coef(input logic [2:0] k);
        logic signed [IW_DEF-1:0] c;
        case (k)
            3'd0:    c = IW_DEF'(TAN_COEF[0]);
            3'd1:    c = IW_DEF'(TAN_COEF[1]);
            3'd2:    c = IW_DEF'(TAN_COEF[2]);
            3'd3:    c = IW_DEF'(TAN_COEF[3]);
            3'd4:    c = IW_DEF'(TAN_COEF[4]);
            3'd5:    c = IW_DEF'(TAN_COEF[5]);
            default: c = {IW_DEF{1'b0}};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tan_clenshaw_seq_if.sv
// Handshake bundle of the tan evaluator: valid/ready request with the angle,
// and a one-cycle result strobe with the registered tan value.
interface tan_clenshaw_seq_if #(parameter int W = tan_pkg::W_DEF);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic                out_valid;
    logic signed [W:0]   f_out;

    // Source side: issues angles and collects results.
    modport master (
        output in_valid,
        output x_in,
        input  in_ready,
        input  out_valid,
        input  f_out
    );

    // Evaluator side.
    modport slave (
        input  in_valid,
        input  x_in,
        output in_ready,
        output out_valid,
        output f_out
    );

endinterface

// File: rtl/tan_clenshaw_seq_clenshaw_step.sv
// One Clenshaw step: d_out = (x*d_next)/2^F - d_next2 + coef, with F = 7 for
// the recurrence and F = 8 for the final combine. Division truncates toward
// zero (signed "/"), which is not the same as an arithmetic shift for
// negative products.
module clenshaw_step
    import tan_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = IW_DEF
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [IW-1:0] d_next,
    input  logic signed [IW-1:0] d_next2,
    input  logic signed [IW-1:0] coef,
    input  logic                 sel_final,
    output logic signed [IW-1:0] d_out
);

    localparam int PW = W + IW;
    localparam logic signed [PW-1:0] DIV_STEP  = PW'(64'sd1 <<< FRAC_STEP);
    localparam logic signed [PW-1:0] DIV_FINAL = PW'(64'sd1 <<< FRAC_FINAL);

    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] quo_s;

    assign prod_s = PW'(x) * PW'(d_next);

    // Scale the full-width product by the step or final fraction.
    always_comb begin
        quo_s = {PW{1'b0}};
        if (sel_final) begin
            quo_s = prod_s / DIV_FINAL;
        end else begin
            quo_s = prod_s / DIV_STEP;
        end
    end

    assign d_out = IW'(quo_s - PW'(d_next2) + PW'(coef));

endmodule

// File: rtl/tan_clenshaw_seq.sv
// tan(x*pi/4) via a truncated odd Chebyshev series evaluated with Clenshaw's
// recurrence, one term per clock on a single shared step unit.
// Optional debug taps (dbg_d, dbg_k) are present when TAN_DBG_EN is defined.
module tan_clenshaw_seq
    import tan_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int L  = L_DEF,
    parameter int IW = W + 3
) (
    input  logic                 clk,
    input  logic                 reset,
    tan_clenshaw_seq_if.slave    bus
`ifdef TAN_DBG_EN
    ,
    output logic signed [IW-1:0] dbg_d,
    output logic [2:0]           dbg_k
`endif
);

    tan_state_e           state_r;
    logic [2:0]           k_r;
    logic signed [W-1:0]  x_r;
    logic signed [IW-1:0] d1_r;      // d[k+1]
    logic signed [IW-1:0] d2_r;      // d[k+2]
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic signed [W:0]    f_out_r;

    logic signed [IW-1:0] coef_s;
    logic signed [IW-1:0] step_d_s;
    logic                 sel_final_s;

    // k is 0 in FINAL, where c0 = 0 makes the final combine coefficient-free.
    assign coef_s      = IW'(tan_coef(k_r));
    assign sel_final_s = (state_r == FINAL);

    clenshaw_step #(
        .W  (W),
        .IW (IW)
    ) u_step (
        .x         (x_r),
        .d_next    (d1_r),
        .d_next2   (d2_r),
        .coef      (coef_s),
        .sel_final (sel_final_s),
        .d_out     (step_d_s)
    );

    // Sequencer: accept an angle, run L recurrence steps, then the final combine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            k_r         <= 3'd0;
            x_r         <= {W{1'b0}};
            d1_r        <= {IW{1'b0}};
            d2_r        <= {IW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            f_out_r     <= {(W+1){1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r        <= bus.x_in;
                        k_r        <= 3'(L);
                        d1_r       <= {IW{1'b0}};
                        d2_r       <= {IW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ITER;
                    end
                end
                ITER: begin
                    d2_r <= d1_r;
                    d1_r <= step_d_s;
                    k_r  <= k_r - 3'd1;
                    if (k_r == 3'd1) begin
                        state_r <= FINAL;
                    end
                end
                FINAL: begin
                    f_out_r     <= step_d_s[W:0];
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b1;
                    k_r        <= 3'd0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.f_out     = f_out_r;

`ifdef TAN_DBG_EN
    // Expose the term being registered this cycle and its index; zero when idle.
    always_comb begin
        dbg_d = {IW{1'b0}};
        dbg_k = 3'd0;
        if (state_r == IDLE) begin
            dbg_d = {IW{1'b0}};
            dbg_k = 3'd0;
        end else begin
            dbg_d = step_d_s;
            dbg_k = k_r;
        end
    end
`endif

endmodule

// File: tb/tb_tan_clenshaw_seq.sv
// Self-checking bench for tan_clenshaw_seq: directed corner cases, back-to-back
// issue, busy-time requests, mid-operation reset and random angles against a
// plain-arithmetic Chebyshev/Clenshaw model. Debug taps checked under TAN_DBG_EN.
module tb_tan_clenshaw_seq;

    localparam int W  = 9;
    localparam int IW = W + 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    tan_clenshaw_seq_if #(.W(W)) bus ();

`ifdef TAN_DBG_EN
    logic signed [IW-1:0] dbg_d;
    logic [2:0]           dbg_k;
`endif

    tan_clenshaw_seq #(.W(W), .L(5), .IW(IW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
`ifdef TAN_DBG_EN
        ,
        .dbg_d (dbg_d),
        .dbg_k (dbg_k)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: d[k] = (x*d[k+1])/128 - d[k+2] + c[k]; f = (x*d[1])/256 - d[2].
    // kk = 1..5 returns that term, kk = 0 returns f.
    function automatic int model_d(input int x, input int kk);
        int c [0:5];
        int d [0:7];
        c = '{0, 240, 0, 15, 0, 1};
        for (int i = 0; i < 8; i++) d[i] = 0;
        for (int k = 5; k >= 1; k--) d[k] = (x * d[k+1]) / 128 - d[k+2] + c[k];
        if (kk == 0) return (x * d[1]) / 256 - d[2];
        return d[kk];
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for out_valid; returns edges since acceptance or 0 on timeout.
    task automatic wait_result(input int x, input int start_edge, output int lat);
        int i;
        bit got;
        i   = start_edge;
        got = 1'b0;
        while (!got && i < start_edge + 20) begin
            @(posedge clk);
            @(negedge clk);
            i++;
`ifdef TAN_DBG_EN
            if (i - start_edge <= 5) begin
                check("dbg_k", int'(dbg_k), 5 - (i - start_edge));
                check("dbg_d", int'(dbg_d), model_d(x, 5 - (i - start_edge)));
            end
`endif
            if (bus.out_valid === 1'b1) got = 1'b1;
        end
        lat = got ? (i - start_edge) : 0;
    endtask

    // Issue one angle from a negedge and check latency, result and strobe width.
    task automatic do_op(input int x, input string tag);
        int lat;
        bus.in_valid = 1'b1;
        bus.x_in     = W'(x);
        check({tag, " ready_idle"}, int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, " ready_busy"}, int'(bus.in_ready), 0);
`ifdef TAN_DBG_EN
        check({tag, " dbg_k0"}, int'(dbg_k), 5);
        check({tag, " dbg_d0"}, int'(dbg_d), model_d(x, 5));
`endif
        wait_result(x, 0, lat);
        check({tag, " latency"}, lat, 6);
        check({tag, " f_out"}, int'(bus.f_out), model_d(x, 0));
        check({tag, " ready_out"}, int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " strobe_1cyc"}, int'(bus.out_valid), 0);
        check({tag, " f_held"}, int'(bus.f_out), model_d(x, 0));
    endtask

    // Count out_valid pulses over n cycles.
    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int xr;
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;          // reset must win over a request
        bus.x_in     = W'(128);

        repeat (3) @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst out_valid", int'(bus.out_valid), 0);
        check("rst f_out", int'(bus.f_out), 0);
        check("rst in_ready", int'(bus.in_ready), 1);
        count_pulses(8, cnt);
        check("rst no_accept", cnt, 0);

        // Directed corner cases.
        do_op(0, "x0");
        check("x0 value", int'(bus.f_out), 0);
        do_op(128, "x128");
        check("x128 value", int'(bus.f_out), 105);
        do_op(-128, "xm128");
        check("xm128 value", int'(bus.f_out), -105);
        do_op(255, "x255");
        check("x255 value", int'(bus.f_out), 250);
        do_op(-256, "xm256");
        check("xm256 value", int'(bus.f_out), -256);

        // Back-to-back: in_valid held, second angle accepted the cycle after out_valid.
        bus.in_valid = 1'b1;
        bus.x_in     = W'(128);
        @(posedge clk);                // acceptance edge 0
        @(negedge clk);
        bus.x_in = W'(-256);
        wait_result(128, 0, lat);
        check("b2b lat1", lat, 6);
        check("b2b f1", int'(bus.f_out), 105);
        check("b2b ready1", int'(bus.in_ready), 1);
        @(posedge clk);                // acceptance edge 7
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b busy2", int'(bus.in_ready), 0);
        check("b2b strobe_drop", int'(bus.out_valid), 0);
        wait_result(-256, 7, lat);
        check("b2b lat2", lat, 6);
        check("b2b f2", int'(bus.f_out), -256);

        // in_valid pulsed while busy must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_in     = W'(128);
        @(posedge clk);                // acceptance edge 0
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;           // presented for edge 3 while busy
        bus.x_in     = W'(64);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result(128, 3, lat);
        check("busy lat", lat, 3);
        check("busy f", int'(bus.f_out), 105);
        count_pulses(12, cnt);
        check("busy single_out", cnt, 0);
        check("busy idle_ready", int'(bus.in_ready), 1);

        // Reset in the middle of a computation discards it.
        bus.in_valid = 1'b1;
        bus.x_in     = W'(128);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);                // reset at edge 3
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst out_valid", int'(bus.out_valid), 0);
        check("mid_rst f_out", int'(bus.f_out), 0);
        check("mid_rst in_ready", int'(bus.in_ready), 1);
        count_pulses(10, cnt);
        check("mid_rst no_out", cnt, 0);
        do_op(0, "post_rst");
        check("post_rst value", int'(bus.f_out), 0);

        // Random angles over the full signed input range.
        for (int n = 0; n < 24; n++) begin
            xr = int'($urandom_range(511, 0)) - 256;
            do_op(xr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tan_clenshaw_seq.md
Name: tan_clenshaw_seq

Overview:
- Sequential inverse companion to the arctan Chebyshev evaluator: computes tan(x·π/4) for signed input x (scale 256 = 1.0) as a truncated odd Chebyshev series.
- Evaluates the series with Clenshaw's recurrence, one term per clock, on a single shared signed multiplier.
- Uses a valid/ready input handshake and a one-cycle output-valid strobe.
- Sits beside the arctan block in the angle/ratio datapath for round-trip checks and for ratio generation.

Parameters:
- W, 9, input bit width; f_out is W+1 bits so that ±1.0 (±256) fits.
- L, 5, series order; number of recurrence steps.
- IW, W+3, internal width of the recurrence terms d[k]; d1 reaches 290.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- in_valid  in  1  x_in is valid.
- in_ready  out  1  high in IDLE; the block accepts when in_valid && in_ready.
- x_in  in  W  signed angle; 256 corresponds to π/4.
- out_valid  out  1  one-cycle strobe; f_out is new.
- f_out  out  W+1  signed tan result; 256 = 1.0; held until the next result.
- dbg_d  out  IW  term being computed (only when TAN_DBG_EN is defined).
- dbg_k  out  3  index of the current term; 0 during the final step (only when TAN_DBG_EN is defined).

Behaviour:
- Coefficients come from the package, scale 256: c1=240, c2=0, c3=15, c4=0, c5=1; c0=0.
- Recurrence, with d[L+1] = d[L+2] = 0:
  - d[k] = (x·d[k+1])/128 − d[k+2] + c[k], for k = L down to 1.
  - Final step: f = (x·d[1])/256 − d[2].
- Division is signed division truncating toward zero (Verilog signed "/"), not an arithmetic shift. Example: −30592/256 = −119.
- Products are full width, W+IW bits. All terms are sign-extended to IW bits. f is truncated to W+1 bits; the result range ±256 fits without overflow.
- FSM states: IDLE, ITER, FINAL.
  - IDLE: in_ready=1. On acceptance: latch x, set k=L, clear both recurrence registers, go to ITER.
  - ITER: one d[k] per clock, shifting the two-deep register pair. When k reaches 1 (after computing d1), go to FINAL.
  - FINAL: compute f, register f_out, pulse out_valid=1 for exactly one cycle, return to IDLE.
- Latency: out_valid rises L+1 clock edges after the acceptance edge (6 for L=5).
  - in_ready is high in the out_valid cycle, so back-to-back issue is allowed.
  - Throughput: one result per L+2 cycles.
- in_valid while busy (in_ready=0) is ignored. No queuing; the source must hold its data.
- Reset (sync, including mid-operation):
  - state=IDLE, out_valid=0, f_out=0, recurrence registers=0, dbg outputs=0.
  - in_ready=1 on the first cycle after reset deasserts.
  - A partial computation is discarded and produces no out_valid.
- in_valid together with reset: reset wins; nothing is accepted.

Optional Feature:
- Macro: TAN_DBG_EN.
- Defined: ports dbg_d and dbg_k exist. Each ITER/FINAL cycle they show the value being registered and its index. In IDLE they are 0.
- Undefined: these ports and their logic are absent. Timing and results are identical either way.

Decomposition:
- Package tan_pkg holds:
  - W_DEF and L_DEF.
  - Constant array TAN_COEF[0:L_DEF] = {0,240,0,15,0,1}.
  - FSM state typedef {IDLE, ITER, FINAL}.
  - Fraction-bit constants 7 (step) and 8 (final).
- One sub-module, clenshaw_step: combinational multiply / truncating divide / subtract / add-coefficient, with a select for the /128 or /256 scale. It is reused for every step.

Test Plan:
- x_in=0 → out_valid exactly 6 cycles after acceptance, f_out=0; with TAN_DBG_EN, terms d5..d1 = 1,0,14,0,226.
- x_in=128 → f_out=105; x_in=−128 → f_out=−105 (checks truncation symmetry).
- x_in=255 → f_out=250 (d1=280, exercises IW width); x_in=−256 → f_out=−256.
- Back-to-back: in_valid held high with 128, then −256 → accepted at cycles 0 and 7; out_valid at cycles 6 and 13 with 105 and −256.
- in_valid pulsed at cycle 3 while busy → ignored, single output only.
- Reset asserted at cycle 3 of an x=128 computation → no out_valid, f_out=0, in_ready=1 after release; a fresh x=0 then yields 0.
